// File: rtl/stat_delta_gen.sv
`default_nettype none
// ============================================================================
// Module      : stat_delta_gen
// Description : Test-pattern transmitter for the delta-pulse statistics path.
//               On start it raises out_live and emits a programmed number of
//               isolated single-cycle ET/veto pulses at a fixed period. Each
//               pulse is surrounded by all-zero cycles. It then drops out_live
//               after a short tail. gen_count = 0 runs until gen_stop.
// Ports       : clk, rst_n (sync, active-low)
//               gen_start, gen_stop             run control
//               gen_et_val, gen_veto_ptn,
//               gen_period, gen_count           run setup, latched at start
//               out_live, out_et[16:0],
//               out_veto[15:0]                  streams to the delta monitor
//               busy, nsent[15:0]               status
// Revision    : 1.0 - initial release
// ============================================================================
module stat_delta_gen #(
    parameter int LEAD_CYC = 3,
    parameter int TAIL_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gen_start,
    input  logic        gen_stop,
    input  logic [15:0] gen_et_val,
    input  logic [15:0] gen_veto_ptn,
    input  logic [15:0] gen_period,
    input  logic [15:0] gen_count,
    output logic        out_live,
    output logic [16:0] out_et,
    output logic [15:0] out_veto,
    output logic        busy,
    output logic [15:0] nsent
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEAD  = 3'd1;
    localparam logic [2:0] S_PULSE = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_TAIL  = 3'd4;

    // Phase counters count down to 0 on the last cycle of the phase.
    localparam logic [15:0] c_LEAD_LOAD = 16'(LEAD_CYC - 1);
    localparam logic [15:0] c_TAIL_LOAD = 16'(TAIL_CYC - 1);

    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_et_val;
    logic [15:0] r_veto_ptn;
    logic [15:0] r_period_m1;
    logic [15:0] r_count;
    logic [15:0] r_nsent;
    logic        r_live;
    logic [16:0] r_et;
    logic [15:0] r_veto;
    logic        r_busy;

    logic [2:0]  w_state_nxt;
    logic [15:0] w_cnt_nxt;
    logic [15:0] w_nsent_nxt;
    logic [15:0] w_nsent_inc;
    logic [15:0] w_period_m1;
    logic        w_start;

    // Period is clamped to 2 so a zero cycle always separates two pulses.
    assign w_period_m1 = (gen_period < 16'd2) ? 16'd1 : (gen_period - 16'd1);
    assign w_nsent_inc = (r_nsent == 16'hFFFF) ? r_nsent : (r_nsent + 16'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_nsent_nxt = r_nsent;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Start takes priority over a simultaneous stop.
                if (gen_start) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_LEAD;
                    w_cnt_nxt   = c_LEAD_LOAD;
                    w_nsent_nxt = 16'd0;
                end
            end
            S_LEAD: begin
                if (gen_stop) begin
                    w_state_nxt = S_TAIL;
                    w_cnt_nxt   = c_TAIL_LOAD;
                end else if (r_cnt == 16'd0) begin
                    w_state_nxt = S_PULSE;
                    w_nsent_nxt = w_nsent_inc;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            S_PULSE: begin
                // r_nsent already includes the pulse on the wire now.
                if (gen_stop || ((r_count != 16'd0) && (r_nsent == r_count))) begin
                    w_state_nxt = S_TAIL;
                    w_cnt_nxt   = c_TAIL_LOAD;
                end else begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = r_period_m1;
                end
            end
            S_GAP: begin
                // Loaded with period-1; the GAP phase lasts period-1 cycles.
                if (gen_stop) begin
                    w_state_nxt = S_TAIL;
                    w_cnt_nxt   = c_TAIL_LOAD;
                end else if (r_cnt <= 16'd1) begin
                    w_state_nxt = S_PULSE;
                    w_nsent_nxt = w_nsent_inc;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            S_TAIL: begin
                if (r_cnt == 16'd0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 16'd0;
            r_et_val    <= 16'd0;
            r_veto_ptn  <= 16'd0;
            r_period_m1 <= 16'd1;
            r_count     <= 16'd0;
            r_nsent     <= 16'd0;
            r_live      <= 1'b0;
            r_et        <= 17'd0;
            r_veto      <= 16'd0;
            r_busy      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_nsent <= w_nsent_nxt;
            if (w_start) begin
                r_et_val    <= gen_et_val;
                r_veto_ptn  <= gen_veto_ptn;
                r_period_m1 <= w_period_m1;
                r_count     <= gen_count;
            end
            // Outputs are registered from the next state so they line up
            // with the cycle the FSM is in.
            r_live <= (w_state_nxt != S_IDLE);
            r_busy <= (w_state_nxt != S_IDLE);
            if (w_state_nxt == S_PULSE) begin
                r_et   <= {1'b0, r_et_val};
                r_veto <= r_veto_ptn;
            end else begin
                r_et   <= 17'd0;
                r_veto <= 16'd0;
            end
        end
    end

    assign out_live = r_live;
    assign out_et   = r_et;
    assign out_veto = r_veto;
    assign busy     = r_busy;
    assign nsent    = r_nsent;

endmodule
`default_nettype wire

// File: tb/tb_stat_delta_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_stat_delta_gen
// Description : Scoreboard bench for stat_delta_gen. Each run's expected
//               per-cycle outputs are derived from pulse-time arithmetic and
//               queued; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stat_delta_gen;

    localparam int LEAD = 3;
    localparam int TAIL = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        gen_start;
    logic        gen_stop;
    logic [15:0] gen_et_val;
    logic [15:0] gen_veto_ptn;
    logic [15:0] gen_period;
    logic [15:0] gen_count;
    logic        out_live;
    logic [16:0] out_et;
    logic [15:0] out_veto;
    logic        busy;
    logic [15:0] nsent;

    stat_delta_gen #(
        .LEAD_CYC (LEAD),
        .TAIL_CYC (TAIL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gen_start    (gen_start),
        .gen_stop     (gen_stop),
        .gen_et_val   (gen_et_val),
        .gen_veto_ptn (gen_veto_ptn),
        .gen_period   (gen_period),
        .gen_count    (gen_count),
        .out_live     (out_live),
        .out_et       (out_et),
        .out_veto     (out_veto),
        .busy         (busy),
        .nsent        (nsent)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        live;
        logic [16:0] et;
        logic [15:0] veto;
        logic        busy;
        logic [15:0] nsent;
    } obs_t;

    obs_t exp_q[$];
    int   n_pass = 0;
    int   n_chk  = 0;
    int   run_id = 0;
    int   cyc_id = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t e;
            obs_t a;
            e = exp_q.pop_front();
            a = '{out_live, out_et, out_veto, busy, nsent};
            cyc_id++;
            n_chk++;
            if (a === e) n_pass++;
            else $display("FAIL run%0d cyc%0d live/et/veto/busy/nsent got %0b/%h/%h/%0b/%0d exp %0b/%h/%h/%0b/%0d",
                          run_id, cyc_id, a.live, a.et, a.veto, a.busy, a.nsent,
                          e.live, e.et, e.veto, e.busy, e.nsent);
        end
    end

    // One run: start in cycle 0, optional stop/reset/restart at later cycles
    // (cycle k is the k-th cycle after the start edge).
    task automatic run(input logic [15:0] et, input logic [15:0] veto,
                       input logic [15:0] per, input logic [15:0] cnt,
                       input int stop_at, input int rst_at, input int restart_at,
                       input bit stop_with_start);
        int pe, nat_end, fin, ncyc, np;
        int pcyc[$];
        obs_t e;
        run_id++;
        cyc_id = 0;
        if (cnt == 16'd0 && stop_at <= 0) stop_at = 20;
        pe = (per < 16'd2) ? 2 : int'(per);
        nat_end = (cnt != 16'd0) ? (LEAD + 1 + (int'(cnt) - 1) * pe) : 1000000;
        fin = (stop_at > 0 && stop_at < nat_end) ? stop_at : nat_end;
        for (int c = LEAD + 1; c <= fin; c += pe) pcyc.push_back(c);
        ncyc = fin + TAIL + 3;
        if (rst_at > 0 && rst_at < ncyc) ncyc = rst_at + 3;

        gen_start    = 1'b1;
        gen_stop     = stop_with_start;
        gen_et_val   = et;
        gen_veto_ptn = veto;
        gen_period   = per;
        gen_count    = cnt;
        @(posedge clk);
        for (int k = 1; k <= ncyc; k++) begin
            if (rst_at > 0 && k > rst_at) begin
                e = '0;
            end else begin
                np = 0;
                foreach (pcyc[i]) if (pcyc[i] <= k) np++;
                e.live  = (k <= fin + TAIL);
                e.busy  = e.live;
                e.nsent = 16'(np);
                e.et    = 17'd0;
                e.veto  = 16'd0;
                foreach (pcyc[i]) if (pcyc[i] == k) begin
                    e.et   = {1'b0, et};
                    e.veto = veto;
                end
            end
            exp_q.push_back(e);
        end
        #1;
        for (int k = 1; k <= ncyc; k++) begin
            gen_start    = (k == restart_at);
            gen_stop     = (k == stop_at);
            rst_n        = !(k == rst_at);
            gen_et_val   = (k == restart_at) ? 16'h00FF : 16'($urandom);
            gen_veto_ptn = 16'($urandom);
            gen_period   = 16'($urandom_range(0, 9));
            gen_count    = 16'($urandom_range(0, 9));
            @(posedge clk);
            #1;
        end
        gen_start = 1'b0;
        gen_stop  = 1'b0;
        rst_n     = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n        = 1'b0;
        gen_start    = 1'b0;
        gen_stop     = 1'b0;
        gen_et_val   = 16'd0;
        gen_veto_ptn = 16'd0;
        gen_period   = 16'd0;
        gen_count    = 16'd0;
        @(posedge clk);
        @(posedge clk);
        exp_q.push_back('0);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Basic: pulses at 4, 9, 14; live through 16.
        run(16'h0065, 16'h0003, 16'd5, 16'd3, -1, -1, -1, 1'b0);
        idle(2);
        // Period clamp.
        run(16'h1234, 16'h00F0, 16'd0, 16'd4, -1, -1, -1, 1'b0);
        idle(1);
        run(16'hABCD, 16'h0F0F, 16'd1, 16'd4, -1, -1, -1, 1'b0);
        idle(1);
        // Continuous with stop.
        run(16'h0042, 16'h0001, 16'd3, 16'd0, 20, -1, -1, 1'b0);
        idle(1);
        // Stop landing on a pulse cycle.
        run(16'h0011, 16'h0002, 16'd3, 16'd0, 10, -1, -1, 1'b0);
        idle(1);
        // Restart mid-run is ignored.
        run(16'h0065, 16'h0003, 16'd5, 16'd3, -1, -1, 6, 1'b0);
        idle(1);
        // Start and stop together in IDLE: start wins.
        run(16'h0077, 16'h0005, 16'd2, 16'd2, -1, -1, -1, 1'b1);
        idle(1);
        // Reset during GAP, then a normal run.
        run(16'h0065, 16'h0003, 16'd5, 16'd3, -1, 6, -1, 1'b0);
        idle(1);
        run(16'h0081, 16'hFFFF, 16'd4, 16'd2, -1, -1, -1, 1'b0);
        idle(1);

        for (int r = 0; r < 30; r++) begin
            logic [15:0] c;
            int s;
            c = 16'($urandom_range(0, 5));
            s = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 30)) : -1;
            run(16'($urandom), 16'($urandom), 16'($urandom_range(0, 7)), c,
                s, -1, -1, 1'b0);
            idle(int'($urandom_range(0, 2)));
        end

        idle(2);
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL queue_drain left %0d expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
